// File: rtl/muldiv_seq_if.sv
`timescale 1ns/1ps
// muldiv_seq_if: request (start/flush/op/operands) and response (busy/done/result/div_zero) of the mul/div unit.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_zero;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// muldiv_seq: shared radix-2 shift-add multiplier / restoring divider; MULDIV_EARLY_OUT_EN skips iteration on a zero operand.
// Latency: done in the cycle after edge E+WIDTH+2; start is ignored while busy (no queueing), flush cancels CALC/FIX.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q;
  logic               sel_hi_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   res_q;
  logic               dz_q;
  logic [WIDTH-1:0]   result_q;
  logic               div_zero_q;
  logic               done_q;

  logic               in_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               accept;
  logic               early_out;

  assign in_signed = ~bus.op[1];
  assign a_neg     = in_signed & bus.a[WIDTH-1];
  assign b_neg     = in_signed & bus.b[WIDTH-1];
  assign abs_a     = a_neg ? -bus.a : bus.a;
  assign abs_b     = b_neg ? -bus.b : bus.b;
  assign accept    = bus.start & ~bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
  // A zero operand makes both product and quotient/remainder zero; FIX handles b==0 overrides.
  assign early_out = (bus.a == '0) || (bus.b == '0);
`else
  assign early_out = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}, multiplier consumed LSB first.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shifted remainder needs one extra bit.
  logic [WIDTH:0]     div_hi;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_nxt;
  assign div_hi  = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge  = div_hi >= {1'b0, opb_q};
  assign div_sub = div_hi[WIDTH-1:0] - opb_q;
  assign div_nxt = {div_ge ? div_sub : div_hi[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               b_zero;
  logic [WIDTH-1:0]   fix_res;
  logic               fix_dz;

  assign prod_fix = (sa_q ^ sb_q) ? -acc : acc;
  assign quot_fix = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign b_zero   = (opb_q == '0);
  assign fix_dz   = is_div_q & b_zero;

  always_comb begin
    fix_res = '0;
    case ({is_div_q, sel_hi_q})
      2'b00:   fix_res = prod_fix[WIDTH-1:0];
      2'b01:   fix_res = prod_fix[2*WIDTH-1:WIDTH];
      2'b10:   fix_res = b_zero ? '1 : quot_fix;
      default: fix_res = b_zero ? a_q : rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = early_out ? FIX : CALC;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = bus.flush ? IDLE : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      a_q        <= '0;
      opb_q      <= '0;
      acc        <= '0;
      res_q      <= '0;
      dz_q       <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            is_div_q <= bus.op[2];
            sel_hi_q <= bus.op[0];
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            a_q      <= bus.a;
            opb_q    <= abs_b;
            cnt      <= '0;
            acc      <= early_out ? '0 : {{WIDTH{1'b0}}, abs_a};
          end
        end
        CALC: begin
          acc <= is_div_q ? div_nxt : mul_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          res_q <= fix_res;
          dz_q  <= fix_dz;
        end
        DONE: begin
          // Outputs only change here, so a flushed op leaves the previous result intact.
          result_q   <= res_q;
          div_zero_q <= dz_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// tb_muldiv_seq: scoreboard bench for muldiv_seq (latency, sign handling, divide-by-zero, flush, reset, busy).
module tb_muldiv_seq;

  localparam int W        = 32;
  localparam int FULL_LAT = W + 2;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [31:0] last_res = '0;
  logic        last_dz  = 1'b0;

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 32'd0 || b == 32'd0) return 2;
`endif
    return FULL_LAT;
  endfunction

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return {1'b0, p[31:0]}; end
      3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
      3'd2: begin p = ua * ub; return {1'b0, p[31:0]}; end
      3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
      3'd4: begin if (b == 0) return {1'b1, 32'hFFFF_FFFF}; p = sa / sb; return {1'b0, p[31:0]}; end
      3'd5: begin if (b == 0) return {1'b1, a}; p = sa % sb; return {1'b0, p[31:0]}; end
      3'd6: begin if (b == 0) return {1'b1, 32'hFFFF_FFFF}; p = ua / ub; return {1'b0, p[31:0]}; end
      default: begin if (b == 0) return {1'b1, a}; p = ua % ub; return {1'b0, p[31:0]}; end
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic edz, input bit push);
    if (push) sb_q.push_back('{er, edz, exp_lat(a, b)});
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int c = c0 + 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  t_op [4] = '{3'd2, 3'd3, 3'd0, 3'd1};
    logic [31:0] t_a  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] t_b  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7};
    logic [31:0] t_r  [4] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFF};
    exp_t e;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_r[i], 1'b0, 1'b1);
      wait_done(0, lat);
      e = sb_q.pop_front();
      checks++; if (bus.result !== e.res) begin errors++; $display("FAIL mul[%0d] result got %h want %h", i, bus.result, e.res); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL mul[%0d] div_zero got %b want %b", i, bus.div_zero, e.dz); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, e.lat); end
      last_res = e.res;
      last_dz  = e.dz;
    end
  endtask

  task automatic test_div();
    logic [2:0]  t_op [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] t_a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] t_b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] t_r  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    exp_t e;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_r[i], 1'b0, 1'b1);
      wait_done(0, lat);
      e = sb_q.pop_front();
      checks++; if (bus.result !== e.res) begin errors++; $display("FAIL div[%0d] result got %h want %h", i, bus.result, e.res); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL div[%0d] div_zero got %b want %b", i, bus.div_zero, e.dz); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL div[%0d] latency got %0d want %0d", i, lat, e.lat); end
      last_res = e.res;
      last_dz  = e.dz;
    end
  endtask

  task automatic test_div_zero();
    logic [2:0]  t_op [6] = '{3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd6};
    logic [31:0] t_a  [6] = '{32'h1234, 32'h1234, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0, 32'd0};
    logic [31:0] t_b  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h55, 32'd9};
    logic [31:0] t_r  [6] = '{32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd0, 32'd0};
    logic        t_dz [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_t e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_r[i], t_dz[i], 1'b1);
      wait_done(0, lat);
      e = sb_q.pop_front();
      checks++; if (bus.result !== e.res) begin errors++; $display("FAIL dz[%0d] result got %h want %h", i, bus.result, e.res); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL dz[%0d] div_zero got %b want %b", i, bus.div_zero, e.dz); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL dz[%0d] latency got %0d want %0d", i, lat, e.lat); end
      last_res = e.res;
      last_dz  = e.dz;
    end
  endtask

  task automatic test_overflow_busy_start();
    exp_t e;
    int   lat;
    int   extra;
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(5, lat);
    e = sb_q.pop_front();
    checks++; if (bus.result !== e.res) begin errors++; $display("FAIL ovf result got %h want %h", bus.result, e.res); end
    checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL ovf div_zero got %b want %b", bus.div_zero, e.dz); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL ovf latency got %0d want %0d", lat, e.lat); end
    last_res = e.res;
    last_dz  = e.dz;
    extra = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_ignored extra_activity got %0d want 0", extra); end
  endtask

  task automatic test_flush();
    int extra;
    issue(3'd6, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    extra = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", extra); end
    checks++; if (bus.result !== last_res) begin errors++; $display("FAIL flush_result got %h want %h", bus.result, last_res); end
    checks++; if (bus.div_zero !== last_dz) begin errors++; $display("FAIL flush_div_zero got %b want %b", bus.div_zero, last_dz); end
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    int          lat;
    logic [32:0] m;
    issue(3'd2, 32'h0001_2345, 32'h777, 32'd0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 0", bus.result); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL rst_mid_div_zero got %b want 0", bus.div_zero); end
    @(negedge clk);
    rst = 1'b0;
    m = model(3'd4, 32'hFFFF_FF9C, 32'd7);
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, m[31:0], m[32], 1'b1);
    wait_done(0, lat);
    e = sb_q.pop_front();
    checks++; if (bus.result !== e.res) begin errors++; $display("FAIL post_rst result got %h want %h", bus.result, e.res); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL post_rst latency got %0d want %0d", lat, e.lat); end
    last_res = e.res;
    last_dz  = e.dz;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    issue(3'd0, 32'd12345, 32'hFFFF_FFF6, 32'hFFFE_1DC6, 1'b0, 1'b1);
    wait_done(0, lat);
    e = sb_q.pop_front();
    checks++; if (bus.result !== e.res) begin errors++; $display("FAIL b2b_first result got %h want %h", bus.result, e.res); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_first latency got %0d want %0d", lat, e.lat); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
    issue(3'd7, 32'd1000, 32'd33, 32'd10, 1'b0, 1'b1);
    wait_done(0, lat);
    e = sb_q.pop_front();
    checks++; if (bus.result !== e.res) begin errors++; $display("FAIL b2b_second result got %h want %h", bus.result, e.res); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_second latency got %0d want %0d", lat, e.lat); end
    last_res = e.res;
    last_dz  = e.dz;
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] m;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'd0;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      m = model(op, a, b);
      issue(op, a, b, m[31:0], m[32], 1'b1);
      wait_done(0, lat);
      e = sb_q.pop_front();
      checks++; if (bus.result !== e.res) begin errors++; $display("FAIL rnd[%0d] op %0d a %h b %h result got %h want %h", i, op, a, b, bus.result, e.res); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL rnd[%0d] div_zero got %b want %b", i, bus.div_zero, e.dz); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL rnd[%0d] latency got %0d want %0d", i, lat, e.lat); end
      last_res = e.res;
      last_dz  = e.dz;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow_busy_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
